// File: rtl/conv_encoder_punct.sv
// K=7 (133,171) convolutional encoder with rate-dependent puncturing for an 802.11a-style TX chain.
// SIGNAL bits are always rate 1/2; DATA bits are punctured per the RATE latched at the end of SIGNAL.
module conv_encoder_punct #(
  parameter int unsigned SIGNAL_BITS = 24,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start_i,
  input  logic             in_valid_i,
  input  logic             in_bit_i,
  input  logic [3:0]       rate_i,
  input  logic [CNT_W-1:0] data_bits_i,
  output logic             out_a_o,
  output logic             out_b_o,
  output logic             out_a_en_o,
  output logic             out_b_en_o,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             rate_err_o
);

  typedef enum logic [1:0] {StIdle, StSignal, StData, StDone} state_e;
  typedef enum logic [1:0] {PunHalf, PunTwoThirds, PunThreeQuarters} punct_e;

  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] SigLast = CNT_W'(SIGNAL_BITS - 1);

  state_e           state_q, state_d;
  punct_e           mode_q, mode_d, rate_mode;
  logic [5:0]       sr_q, sr_d;  // sr_q[0] is d1 (most recent bit)
  logic [CNT_W-1:0] cnt_q, cnt_d, data_bits_q, data_bits_d;
  logic [1:0]       phase_q, phase_d, phase_next;
  logic             rate_err_q, rate_err_d, rate_bad;
  logic             out_a_q, out_a_d, out_b_q, out_b_d;
  logic             out_a_en_q, out_a_en_d, out_b_en_q, out_b_en_d;
  logic             busy_q, busy_d, frame_done_q, frame_done_d;
  logic             accept, sig_last, data_last, coded_a, coded_b, a_mask, b_mask;

  // start wins over a coincident valid bit
  assign accept    = in_valid_i & ~start_i & ((state_q == StSignal) | (state_q == StData));
  assign sig_last  = (state_q == StSignal) & (cnt_q == SigLast);
  assign data_last = (state_q == StData) & (cnt_q == (data_bits_q - CntOne));
  assign coded_a   = in_bit_i ^ sr_q[1] ^ sr_q[2] ^ sr_q[4] ^ sr_q[5];
  assign coded_b   = in_bit_i ^ sr_q[0] ^ sr_q[1] ^ sr_q[2] ^ sr_q[5];

  always_comb begin
    rate_mode = PunHalf;
    rate_bad  = 1'b0;
    case (rate_i)
      4'b1101, 4'b0101, 4'b1001:          rate_mode = PunHalf;
      4'b0001:                            rate_mode = PunTwoThirds;
      4'b1111, 4'b0111, 4'b1011, 4'b0011: rate_mode = PunThreeQuarters;
      default:                            rate_bad  = 1'b1;
    endcase
  end

  always_comb begin
    case (mode_q)
      PunTwoThirds:     phase_next = (phase_q == 2'd1) ? 2'd0 : phase_q + 2'd1;
      PunThreeQuarters: phase_next = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
      default:          phase_next = 2'd0;
    endcase
  end

  // State register
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   state_d = StIdle;
      StSignal: if (accept && sig_last) state_d = (data_bits_q == '0) ? StDone : StData;
      StData:   if (accept && data_last) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (start_i) state_d = StSignal;
  end

  // Datapath next-state: shift register, counter, phase and latched rate
  always_comb begin
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    data_bits_d = data_bits_q;
    mode_d      = mode_q;
    rate_err_d  = rate_err_q;
    phase_d     = phase_q;
    if (start_i) begin
      sr_d        = '0;
      cnt_d       = '0;
      data_bits_d = data_bits_i;
      mode_d      = PunHalf;
      rate_err_d  = 1'b0;
      phase_d     = 2'd0;
    end else if (accept) begin
      sr_d  = {sr_q[4:0], in_bit_i};
      cnt_d = cnt_q + CntOne;
      if (sig_last) begin
        cnt_d      = '0;
        mode_d     = rate_mode;
        rate_err_d = rate_bad;
        phase_d    = 2'd0;
      end else if (state_q == StData) begin
        phase_d = phase_next;
      end
    end
  end

  // Output logic (registered below)
  always_comb begin
    a_mask = 1'b1;
    b_mask = 1'b1;
    if (state_q == StData) begin
      case (mode_q)
        PunTwoThirds: b_mask = (phase_q == 2'd0);
        PunThreeQuarters: begin
          a_mask = (phase_q != 2'd2);
          b_mask = (phase_q != 2'd1);
        end
        default: ;
      endcase
    end
    out_a_d      = accept & coded_a;
    out_b_d      = accept & coded_b;
    out_a_en_d   = accept & a_mask;
    out_b_en_d   = accept & b_mask;
    // busy spans through the frame_done cycle, one past StDone
    busy_d       = (state_d != StIdle) | (state_q == StDone);
    frame_done_d = (state_q == StDone) & ~start_i;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      sr_q         <= '0;
      cnt_q        <= '0;
      data_bits_q  <= '0;
      mode_q       <= PunHalf;
      rate_err_q   <= 1'b0;
      phase_q      <= 2'd0;
      out_a_q      <= 1'b0;
      out_b_q      <= 1'b0;
      out_a_en_q   <= 1'b0;
      out_b_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      data_bits_q  <= data_bits_d;
      mode_q       <= mode_d;
      rate_err_q   <= rate_err_d;
      phase_q      <= phase_d;
      out_a_q      <= out_a_d;
      out_b_q      <= out_b_d;
      out_a_en_q   <= out_a_en_d;
      out_b_en_q   <= out_b_en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_a_o      = out_a_q;
  assign out_b_o      = out_b_q;
  assign out_a_en_o   = out_a_en_q;
  assign out_b_en_o   = out_b_en_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;
  assign rate_err_o   = rate_err_q;

endmodule

// File: tb/tb_conv_encoder_punct.sv
// Bench for conv_encoder_punct: table of frame scenarios, hand-written corner sequences and random
// frames, all checked against a frame-level model built from whole input bit lists.
module tb_conv_encoder_punct;
  localparam int SigBits = 24;
  localparam int CntW    = 16;

  logic            Clk = 1'b0;
  logic            Reset;
  logic            start, in_valid, in_bit;
  logic [3:0]      rate_in;
  logic [CntW-1:0] data_bits;
  logic            out_a, out_b, out_a_en, out_b_en, busy, frame_done, rate_err;

  conv_encoder_punct #(
    .SIGNAL_BITS(SigBits),
    .CNT_W      (CntW)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .start_i     (start),
    .in_valid_i  (in_valid),
    .in_bit_i    (in_bit),
    .rate_i      (rate_in),
    .data_bits_i (data_bits),
    .out_a_o     (out_a),
    .out_b_o     (out_b),
    .out_a_en_o  (out_a_en),
    .out_b_en_o  (out_b_en),
    .busy_o      (busy),
    .frame_done_o(frame_done),
    .rate_err_o  (rate_err)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {logic a; logic b; logic aen; logic ben;} exp_t;
  typedef struct {
    logic [3:0] rate;
    int         ndata;
    int         gap;
    bit         zeros;
    int         exp_tx;
    bit         exp_err;
  } vec_t;

  int   n_checks = 0;
  int   n_err    = 0;
  bit   stim[$];
  exp_t exp_q[$];
  logic exp_err;
  logic obs_a[$];
  logic obs_b[$];
  int   en_both;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // 0: rate 1/2, 1: 2/3, 2: 3/4
  function automatic int rate_mode(input logic [3:0] r);
    case (r)
      4'b0001:                            return 1;
      4'b1111, 4'b0111, 4'b1011, 4'b0011: return 2;
      default:                            return 0;
    endcase
  endfunction

  function automatic logic rate_illegal(input logic [3:0] r);
    case (r)
      4'b1101, 4'b0101, 4'b1001, 4'b0001, 4'b1111, 4'b0111, 4'b1011, 4'b0011: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic tap(input int i, input int k);
    return (i - k >= 0) ? logic'(stim[i-k]) : 1'b0;
  endfunction

  // Expected coded output per accepted bit, over the whole frame
  function automatic void build_exp(input logic [3:0] rate, input int ndata);
    exp_t e;
    int   mode;
    int   j;
    mode    = rate_mode(rate);
    exp_err = rate_illegal(rate);
    exp_q.delete();
    for (int i = 0; i < SigBits + ndata; i++) begin
      e.a   = tap(i, 0) ^ tap(i, 2) ^ tap(i, 3) ^ tap(i, 5) ^ tap(i, 6);
      e.b   = tap(i, 0) ^ tap(i, 1) ^ tap(i, 2) ^ tap(i, 3) ^ tap(i, 6);
      e.aen = 1'b1;
      e.ben = 1'b1;
      if (i >= SigBits) begin
        j = i - SigBits;
        if (mode == 1) begin
          e.ben = (j % 2) == 0;
        end else if (mode == 2) begin
          e.aen = (j % 3) != 2;
          e.ben = (j % 3) != 1;
        end
      end
      exp_q.push_back(e);
    end
  endfunction

  task automatic fill(input int ndata, input bit zeros);
    stim.delete();
    for (int i = 0; i < SigBits + ndata; i++) stim.push_back(zeros ? 1'b0 : 1'($urandom));
  endtask

  // Runs one frame from the current stim; abort_after >= 0 stops after that many bits
  task automatic run_frame(input logic [3:0] rate, input int ndata, input int gap,
                           input int abort_after, output int tx_data);
    exp_t e;
    int   total;
    int   k;
    int   c;
    int   fd;
    logic acc;
    total   = SigBits + ndata;
    build_exp(rate, ndata);
    obs_a.delete();
    obs_b.delete();
    tx_data = 0;
    en_both = 0;
    fd      = 0;
    start     = 1'b1;
    in_valid  = 1'b1;
    in_bit    = 1'b1;
    rate_in   = 4'($urandom);
    data_bits = CntW'(ndata);
    tick();
    start = 1'b0;
    check("start_en", {out_a_en, out_b_en}, 0);
    check("start_busy", busy, 1);
    check("start_err", rate_err, 0);
    k = 0;
    c = 0;
    while (k < total && (abort_after < 0 || k < abort_after)) begin
      acc = (c % gap) == 0;
      c++;
      in_valid = acc;
      in_bit   = acc ? logic'(stim[k]) : 1'($urandom);
      rate_in  = (acc && k == SigBits - 1) ? rate : 4'($urandom);
      tick();
      if (acc) begin
        e = exp_q[k];
        check("en", {out_a_en, out_b_en}, {e.aen, e.ben});
        if (e.aen) check("bit_a", out_a, e.a);
        if (e.ben) check("bit_b", out_b, e.b);
        obs_a.push_back(out_a);
        obs_b.push_back(out_b);
        if (k >= SigBits) tx_data += int'(out_a_en) + int'(out_b_en);
        if (out_a_en && out_b_en) en_both++;
        k++;
      end else begin
        check("gap_en", {out_a_en, out_b_en}, 0);
      end
      check("busy_frame", busy, 1);
      fd += int'(frame_done);
    end
    if (k < total) return;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    tick();
    check("done_en", {out_a_en, out_b_en}, 0);
    check("done_pulse", frame_done, 1);
    check("done_busy", busy, 1);
    check("model_err", rate_err, exp_err);
    fd += int'(frame_done);
    tick();
    check("idle_busy", busy, 0);
    check("idle_done", frame_done, 0);
    check("idle_en", {out_a_en, out_b_en}, 0);
    check("frame_done_count", fd, 1);
    in_valid = 1'b0;
  endtask

  vec_t vecs[11];

  initial begin
    int         tx;
    int         ones;
    logic [6:0] sa;
    logic [6:0] sb;
    logic [3:0] r;

    vecs[0]  = '{4'b1101, 48, 1, 1'b1, 96, 1'b0};
    vecs[1]  = '{4'b1111, 12, 1, 1'b0, 16, 1'b0};
    vecs[2]  = '{4'b0001,  8, 1, 1'b0, 12, 1'b0};
    vecs[3]  = '{4'b0000,  8, 1, 1'b0, 16, 1'b1};
    vecs[4]  = '{4'b1111, 12, 3, 1'b0, 16, 1'b0};
    vecs[5]  = '{4'b1011,  7, 1, 1'b0, 10, 1'b0};
    vecs[6]  = '{4'b0011,  0, 1, 1'b0,  0, 1'b0};
    vecs[7]  = '{4'b1001,  5, 2, 1'b0, 10, 1'b0};
    vecs[8]  = '{4'b0101,  4, 1, 1'b0,  8, 1'b0};
    vecs[9]  = '{4'b0111,  9, 1, 1'b0, 12, 1'b0};
    vecs[10] = '{4'b1110,  3, 1, 1'b0,  6, 1'b1};

    Reset     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    rate_in   = 4'd0;
    data_bits = '0;
    repeat (3) tick();
    check("reset_outs", {out_a, out_b, out_a_en, out_b_en, busy, frame_done, rate_err}, 0);
    Reset = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    tick();
    check("idle_ignore", {out_a_en, out_b_en, busy}, 0);
    in_valid = 1'b0;

    for (int i = 0; i < 11; i++) begin
      fill(vecs[i].ndata, vecs[i].zeros);
      run_frame(vecs[i].rate, vecs[i].ndata, vecs[i].gap, -1, tx);
      check("tbl_tx", tx, vecs[i].exp_tx);
      check("tbl_err", rate_err, vecs[i].exp_err);
      if (vecs[i].zeros) begin
        ones = 0;
        foreach (obs_a[j]) ones += int'(obs_a[j]) + int'(obs_b[j]);
        check("zero_ones", ones, 0);
        check("zero_pairs", en_both, 72);
      end
    end

    // Impulse response through SIGNAL
    fill(4, 1'b1);
    stim[0] = 1'b1;
    run_frame(4'b1101, 4, 1, -1, tx);
    sa = '0;
    sb = '0;
    for (int i = 0; i < 7; i++) begin
      sa = {sa[5:0], obs_a[i]};
      sb = {sb[5:0], obs_b[i]};
    end
    check("impulse_a", sa, 7'b1011011);
    check("impulse_b", sb, 7'b1111001);

    // Reset mid-DATA, then a fresh frame
    fill(20, 1'b0);
    run_frame(4'b0000, 20, 1, 30, tx);
    check("abort_err", rate_err, 1);
    Reset    = 1'b0;
    in_valid = 1'b1;
    tick();
    check("mid_reset_outs", {out_a, out_b, out_a_en, out_b_en, busy, frame_done, rate_err}, 0);
    Reset = 1'b1;
    repeat (3) begin
      tick();
      check("post_reset_idle", {out_a_en, out_b_en, busy, frame_done}, 0);
    end
    in_valid = 1'b0;
    run_frame(4'b1111, 20, 1, -1, tx);
    check("fresh_tx", tx, 27);

    // start mid-frame restarts cleanly
    fill(16, 1'b0);
    run_frame(4'b0001, 16, 1, 28, tx);
    run_frame(4'b0001, 16, 1, -1, tx);
    check("restart_tx", tx, 24);

    for (int f = 0; f < 8; f++) begin
      int nd;
      int g;
      r  = 4'($urandom);
      nd = $urandom_range(0, 30);
      g  = $urandom_range(1, 3);
      fill(nd, 1'b0);
      run_frame(r, nd, g, -1, tx);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
